// File: rtl/operand_sequencer_pkg.sv
// operand_sequencer_pkg: state codes, operand width and op encodings shared by the sequencer and its ALU
package operand_sequencer_pkg;
  localparam int W = 7;
  localparam logic [2:0] LD_A_LO = 3'd0;
  localparam logic [2:0] LD_A_HI = 3'd1;
  localparam logic [2:0] LD_B_LO = 3'd2;
  localparam logic [2:0] LD_B_HI = 3'd3;
  localparam logic [2:0] LD_OP   = 3'd4;
  localparam logic [2:0] COMPUTE = 3'd5;
  localparam logic [2:0] SHOW    = 3'd6;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/operand_sequencer_if.sv
// operand_sequencer_if: rotary/switch inputs and led display bundle
interface operand_sequencer_if;
  logic       rotation_event;
  logic       rotation_direction;
  logic [3:0] Y;
  logic [7:0] led;
  modport master (output rotation_event, rotation_direction, Y, input led);
  modport slave  (input rotation_event, rotation_direction, Y, output led);
endinterface

// File: rtl/operand_sequencer_add_sub7.sv
// add_sub7: 7-bit add/subtract; bit 7 is carry on add, borrow (A < B) on subtract
module add_sub7
  import operand_sequencer_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         op,
  output logic [7:0]   result
);
  logic [W:0] sum;
  always_comb begin
    sum = (op == OP_SUB) ? {1'b0, A} + {1'b0, ~B} + 8'd1 : {1'b0, A} + {1'b0, B};
    result = {(op == OP_SUB) ? (A < B) : sum[W], sum[W-1:0]};
  end
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: loads two 7-bit operands and an op nibble-wise from a rotary encoder, then shows the result
module operand_sequencer
  import operand_sequencer_pkg::*;
(
  input logic clk,
  input logic rst,
  operand_sequencer_if.slave io
);
  logic [2:0]   state;
  logic [W-1:0] a, b;
  logic         op, prev_evt, evt, fwd, bck;
  logic [7:0]   result, alu;
  add_sub7 u_alu (.A(a), .B(b), .op(op), .result(alu));
  always_comb begin
    evt = io.rotation_event & ~prev_evt;
    fwd = evt & io.rotation_direction;
    bck = evt & ~io.rotation_direction;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_A_LO;
      a        <= '0;
      b        <= '0;
      op       <= OP_ADD;
      result   <= '0;
      io.led   <= '0;
      prev_evt <= 1'b1;
    end else begin
      prev_evt <= io.rotation_event;
      io.led   <= (state == COMPUTE) ? io.led : (state == SHOW) ? result : {state, 1'b0, io.Y};
      if (state <= LD_OP) begin
        if (fwd) begin
          case (state)
            LD_A_LO: a[3:0] <= io.Y;
            LD_A_HI: a[6:4] <= io.Y[2:0];
            LD_B_LO: b[3:0] <= io.Y;
            LD_B_HI: b[6:4] <= io.Y[2:0];
            default: op     <= io.Y[0];
          endcase
          state <= state + 3'd1;
        end else if (bck) begin
          state <= (state == LD_A_LO) ? LD_A_LO : state - 3'd1;
        end
      end else if (state == COMPUTE) begin
        result <= alu;
        state  <= SHOW;
      end else begin
        state <= fwd ? LD_A_LO : bck ? LD_OP : state;
      end
    end
  end
endmodule

// File: tb/tb_operand_sequencer.sv
// tb_operand_sequencer: directed steps with a result scoreboard for operand_sequencer
module tb_operand_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] sb[$];
  operand_sequencer_if bus ();
  operand_sequencer dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] model(int a, int b, bit sub);
    int r;
    r = sub ? a - b : a + b;
    return {sub ? (a < b) : (r > 127), 7'(r & 127)};
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(bit dir, logic [3:0] y);
    @(negedge clk);
    bus.Y = y;
    bus.rotation_direction = dir;
    bus.rotation_event = 1'b1;
    @(negedge clk);
    bus.rotation_event = 1'b0;
  endtask

  task automatic load(logic [3:0] y0, logic [3:0] y1, logic [3:0] y2, logic [3:0] y3, logic [3:0] y4);
    pulse(1, y0); pulse(1, y1); pulse(1, y2); pulse(1, y3);
    sb.push_back(model({y1[2:0], y0}, {y3[2:0], y2}, y4[0]));
    pulse(1, y4);
  endtask

  task automatic check_show(string tag);
    int n = 0;
    while (dut.state !== 3'd6 && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h", tag, bus.led);
    end else if (n >= 8) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s timeout observed_state=%0d expected=6", tag, dut.state);
      void'(sb.pop_front());
    end else chk(tag, bus.led, sb.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    bus.rotation_event = 1'b0;
    bus.rotation_direction = 1'b1;
    bus.Y = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_led", bus.led, 8'h00);
    chk("reset_state", 8'(dut.state), 8'h00);
    rst = 1'b0;
    pulse(1, 4'h5);
    @(negedge clk);
    chk("load_led", bus.led, 8'h25);
    pulse(1, 4'h2); pulse(1, 4'h3); pulse(1, 4'h1);
    sb.push_back(model(8'h25, 8'h13, 0));
    pulse(1, 4'h0);
    chk("a_add", 8'(dut.a), 8'h25);
    chk("b_add", 8'(dut.b), 8'h13);
    check_show("add");
    pulse(1, 4'h0);
    chk("show_fwd", 8'(dut.state), 8'h00);
    load(4'hF, 4'h7, 4'h1, 4'h0, 4'h0);
    check_show("add_ovf");
    pulse(1, 4'h0);
    load(4'h0, 4'h1, 4'h0, 4'h2, 4'h1);
    check_show("sub_borrow");
    pulse(0, 4'h0);
    chk("show_back", 8'(dut.state), 8'h04);
    sb.push_back(model(8'h10, 8'h20, 0));
    pulse(1, 4'h0);
    check_show("readd");
    chk("a_retained", 8'(dut.a), 8'h10);
    pulse(1, 4'h0);
    pulse(0, 4'h9);
    @(negedge clk);
    chk("back_a_lo", 8'(bus.led[7:5]), 8'h00);
    chk("back_a_lo_a", 8'(dut.a), 8'h10);
    pulse(1, 4'h3); pulse(1, 4'h1);
    pulse(0, 4'h0);
    chk("back_b_lo", 8'(dut.state), 8'h01);
    chk("back_b_lo_a", 8'(dut.a), 8'h13);
    @(negedge clk);
    bus.Y = 4'h2;
    bus.rotation_direction = 1'b1;
    bus.rotation_event = 1'b1;
    repeat (10) @(negedge clk);
    bus.rotation_event = 1'b0;
    chk("held_state", 8'(dut.state), 8'h02);
    chk("held_a", 8'(dut.a), 8'h23);
    pulse(1, 4'h4);
    chk("pre_rst_state", 8'(dut.state), 8'h03);
    @(negedge clk);
    bus.Y = 4'h0;
    bus.rotation_event = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_led", bus.led, 8'h00);
    chk("rst_state", 8'(dut.state), 8'h00);
    chk("rst_a", 8'(dut.a), 8'h00);
    chk("rst_b", 8'(dut.b), 8'h00);
    repeat (3) @(negedge clk);
    chk("no_evt_state", 8'(dut.state), 8'h00);
    chk("no_evt_led", bus.led, 8'h00);
    bus.rotation_event = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
